avalon_st_source_skid: RTL

Parametrised, fully registered Avalon-ST source stage for the video IP output path. It replaces the pass-through source wiring with a two-entry skid buffer. `data_out`, `valid_out`, `startofpacket_out`, `endofpacket_out` and `ready_reg` all come from flops, which breaks the combinational ready/valid path between the IP core and the downstream sink. Full throughput of one beat per cycle is kept. An optional packet-framing checker reports malformed frames seen at the output.

---
 rtl/avst_pkg.sv | 19 +
 rtl/avalon_st_source_skid_if.sv | 27 ++
 rtl/avst_pkt_checker.sv | 62 ++++++
 rtl/avalon_st_source_skid.sv | 108 ++++++++++
 4 files changed

// File: rtl/avst_pkg.sv
// Shared types and default widths for the Avalon-ST source skid stage.
package avst_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 16;
    localparam int unsigned DEF_COUNT_WIDTH = 20;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] data;
        logic                      sop;
        logic                      eop;
    } beat_t;

endpackage

// File: rtl/avalon_st_source_skid_if.sv
// Handshake bundle between the IP core, the source stage and the downstream sink.
// master: view of the source stage; slave: view of the surrounding logic.
interface avalon_st_source_skid_if #(
    parameter int unsigned DATA_WIDTH = avst_pkg::DEF_DATA_WIDTH
);
    logic                  valid_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  startofpacket_reg;
    logic                  endofpacket_reg;
    logic                  ready_reg;

    logic                  ready_in;
    logic                  valid_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  startofpacket_out;
    logic                  endofpacket_out;

    modport master (
        input  valid_reg, data_reg, startofpacket_reg, endofpacket_reg, ready_in,
        output ready_reg, valid_out, data_out, startofpacket_out, endofpacket_out
    );

    modport slave (
        output valid_reg, data_reg, startofpacket_reg, endofpacket_reg, ready_in,
        input  ready_reg, valid_out, data_out, startofpacket_out, endofpacket_out
    );
endinterface

// File: rtl/avst_pkt_checker.sv
// Packet-framing checker on the output transfers of the source stage.
// Exists only when AVST_SRC_PKT_CHECK_EN is defined.
`ifdef AVST_SRC_PKT_CHECK_EN
module avst_pkt_checker #(
    parameter int unsigned COUNT_WIDTH = avst_pkg::DEF_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   xfer_i,
    input  logic                   sop_i,
    input  logic                   eop_i,
    output logic                   pkt_error_o,
    output logic [COUNT_WIDTH-1:0] last_pkt_len_o
);
    logic                   in_pkt_q, in_pkt_d;
    logic                   err_q, err_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0] len_q, len_d;

    // Checker state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            in_pkt_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            len_q    <= '0;
        end else begin
            in_pkt_q <= in_pkt_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
        end
    end

    // Framing rules: sop inside a packet or a headless beat sets the sticky error
    always_comb begin
        in_pkt_d = in_pkt_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        if (xfer_i) begin
            if (sop_i) begin
                cnt_d = COUNT_WIDTH'(1);
            end else if (cnt_q != {COUNT_WIDTH{1'b1}}) begin
                cnt_d = cnt_q + COUNT_WIDTH'(1);
            end
            if ((sop_i && in_pkt_q) || (!sop_i && !in_pkt_q)) begin
                err_d = 1'b1;
            end
            if (eop_i) begin
                len_d    = cnt_d;
                in_pkt_d = 1'b0;
            end else if (sop_i) begin
                in_pkt_d = 1'b1;
            end
        end
    end

    assign pkt_error_o    = err_q;
    assign last_pkt_len_o = len_q;
endmodule
`endif

// File: rtl/avalon_st_source_skid.sv
// Fully registered Avalon-ST source stage: two-entry skid buffer (main + skid).
// Optional framing checker enabled by defining AVST_SRC_PKT_CHECK_EN.
module avalon_st_source_skid
    import avst_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    avalon_st_source_skid_if.master bus,
    output logic                    pkt_error,
    output logic [COUNT_WIDTH-1:0]  last_pkt_len
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  sop;
        logic                  eop;
    } entry_t;

    state_e state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_beat;
    logic   valid_q, ready_q;
    logic   acc_c, out_c;

    assign in_beat = entry_t'{data: bus.data_reg,
                              sop:  bus.startofpacket_reg,
                              eop:  bus.endofpacket_reg};
    assign acc_c   = bus.valid_reg & ready_q;
    assign out_c   = valid_q & bus.ready_in;

    // State, storage and registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            valid_q <= (state_d != EMPTY);
            ready_q <= (state_d != FULL);
        end
    end

    // Next state and entry moves; main holds its content when the stage drains
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (acc_c) begin
                    main_d  = in_beat;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (acc_c && !out_c) begin
                    skid_d  = in_beat;
                    state_d = FULL;
                end else if (acc_c && out_c) begin
                    main_d  = in_beat;
                end else if (out_c) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_c) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    assign bus.ready_reg         = ready_q;
    assign bus.valid_out         = valid_q;
    assign bus.data_out          = main_q.data;
    assign bus.startofpacket_out = main_q.sop;
    assign bus.endofpacket_out   = main_q.eop;

`ifdef AVST_SRC_PKT_CHECK_EN
    // Framing checker on output transfers
    avst_pkt_checker #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_checker (
        .clk            (clk),
        .reset          (reset),
        .xfer_i         (out_c),
        .sop_i          (main_q.sop),
        .eop_i          (main_q.eop),
        .pkt_error_o    (pkt_error),
        .last_pkt_len_o (last_pkt_len)
    );
`else
    assign pkt_error    = 1'b0;
    assign last_pkt_len = '0;
`endif
endmodule
